// File: rtl/codeword_seq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : codec_pkg
// Brief    : Shared state encoding and default code geometry for the codec.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package codec_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MSG   = 3'd2,
    PAR   = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } seq_state_t;

  localparam int CW_N = 31;
  localparam int CW_K = 26;

endpackage

`default_nettype wire

// File: rtl/codeword_seq_ctrl_frame_bit_counter.sv
//------------------------------------------------------------------------------
// Module   : frame_bit_counter
// Brief    : Bit index counter 0..N-1, wraps to 0; clear beats enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_bit_counter
  import codec_pkg::*;
#(
  parameter int N     = CW_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_at_last
);

  logic [IDX_W-1:0] r_idx;
  logic             w_at_last;

  assign w_at_last = (r_idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= w_at_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_idx     = r_idx;
  assign o_at_last = w_at_last;

endmodule

`default_nettype wire

// File: rtl/codeword_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : codeword_seq_ctrl
// Brief    : Sequencer stepping a bit-serial (N,K) codec through K message
//            bits then N-K parity bits, with stall and abort handling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module codeword_seq_ctrl
  import codec_pkg::*;
#(
  parameter int N      = CW_N,
  parameter int K      = CW_K,
  parameter int IDX_W  = $clog2(N),
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_req,
  input  logic              i_out_ready,
  input  logic              i_error_abort,
  output logic              o_frame_ack,
  output logic              o_lfsr_clear,
  output logic              o_shift_en,
  output logic              o_sel_parity,
  output logic [IDX_W-1:0]  o_bit_idx,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_frame_abort,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [FCNT_W-1:0]  r_frame_cnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_at_last;
  logic               w_abort;
  logic               w_cnt_en;
  logic               w_cnt_clr;
  logic               w_msg_last;
  logic               w_frame_end;

  // Abort only matters while a frame is in flight; it outranks any advance.
  assign w_abort     = i_error_abort &&
                       (r_state == CLEAR || r_state == MSG || r_state == PAR);
  assign w_cnt_en    = o_shift_en && !i_error_abort;
  assign w_cnt_clr   = w_abort || (r_state == CLEAR);
  assign w_msg_last  = (w_idx == IDX_W'(K - 1));
  assign w_frame_end = (r_state == PAR) && w_cnt_en && w_at_last;

  frame_bit_counter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_idx     (w_idx),
    .o_at_last (w_at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_frame_ack   = 1'b0;
    o_lfsr_clear  = 1'b0;
    o_shift_en    = 1'b0;
    o_sel_parity  = 1'b0;
    o_busy        = 1'b1;
    o_frame_done  = 1'b0;
    o_frame_abort = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_frame_req) w_next = CLEAR;
      end
      CLEAR: begin
        o_frame_ack  = 1'b1;
        o_lfsr_clear = 1'b1;
        w_next       = i_error_abort ? ABORT : MSG;
      end
      MSG: begin
        o_shift_en = i_out_ready;
        if (i_error_abort)                  w_next = ABORT;
        else if (i_out_ready && w_msg_last) w_next = PAR;
      end
      PAR: begin
        o_sel_parity = 1'b1;
        o_shift_en   = i_out_ready;
        if (i_error_abort)                 w_next = ABORT;
        else if (i_out_ready && w_at_last) w_next = DONE;
      end
      DONE: begin
        o_frame_done = 1'b1;
        w_next       = i_frame_req ? CLEAR : IDLE;
      end
      ABORT: begin
        o_frame_abort = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Count lands on the same edge that shifts the final parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
    end
  end

  assign o_bit_idx   = w_idx;
  assign o_frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire
